// File: rtl/barcode_pkg.sv
// Shared types and constants for the station-ID barcode reader.
package barcode_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT_FALL,
      SAMPLE_DLY,
      DONE
   } bc_state_t;

   localparam logic [1:0]  ID_PREFIX = 2'b00;
   localparam int unsigned NUM_BITS  = 8;

   // Only IDs carrying the station prefix in their top two bits are accepted.
   function automatic logic prefix_ok(input logic [NUM_BITS-1:0] v);
      return v[NUM_BITS-1 -: 2] == ID_PREFIX;
   endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for the raw barcode line plus one flop for edge detection.
module sync_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic sync_out,
   output logic fall,
   output logic rise
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   // The line idles high, so reset to 1 to avoid a spurious fall on release.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= async_in;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign sync_out = sync_q;
   assign fall     = prev_q & ~sync_q;
   assign rise     = ~prev_q & sync_q;

endmodule

// File: rtl/barcode_rdr.sv
// Self-timed barcode reader: learns the bit period from the start cell and decodes
// an 8-bit station ID, presented on an ID/ID_vld/clr_ID_vld handshake.
module barcode_rdr #(
   parameter int unsigned CNT_W   = 22,
   parameter int unsigned MIN_LOW = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       BC,
   input  logic       clr_ID_vld,
   output logic [7:0] ID,
   output logic       ID_vld
);

   import barcode_pkg::*;

   localparam int unsigned      BIT_CNT_W = $clog2(NUM_BITS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] MIN_LOW_C = CNT_W'(MIN_LOW);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic bc_sync;
   logic bc_fall;
   logic bc_rise;

   bc_state_t                state_q,   state_d;
   logic [CNT_W-1:0]         cnt_q,     cnt_d;
   logic [CNT_W-1:0]         tlow_q,    tlow_d;
   logic [BIT_CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic [NUM_BITS-1:0]      shift_q,   shift_d;
   logic [NUM_BITS-1:0]      id_q,      id_d;
   logic                     id_vld_q,  id_vld_d;
   logic                     cnt_sat;

   sync_edge_det u_sync_edge_det (
      .clk      (clk),
      .rst      (rst),
      .async_in (BC),
      .sync_out (bc_sync),
      .fall     (bc_fall),
      .rise     (bc_rise)
   );

   assign cnt_sat = (cnt_q == CNT_MAX);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      tlow_d    = tlow_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      id_d      = id_q;
      id_vld_d  = id_vld_q & ~clr_ID_vld;

      unique case (state_q)
         IDLE: begin
            cnt_d     = '0;
            bit_cnt_d = '0;
            if (bc_fall) begin
               state_d = START;
            end
         end

         START: begin
            if (bc_rise) begin
               cnt_d = '0;
               if (cnt_q < MIN_LOW_C) begin
                  state_d = IDLE;
               end else begin
                  tlow_d  = cnt_q;
                  state_d = WAIT_FALL;
               end
            end else if (cnt_sat) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         WAIT_FALL: begin
            if (bc_fall) begin
               cnt_d   = '0;
               state_d = SAMPLE_DLY;
            end else if (cnt_sat) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         // Falls are deliberately not looked at here: the line level is all that matters.
         SAMPLE_DLY: begin
            if (cnt_q == tlow_q - CNT_ONE) begin
               shift_d   = {shift_q[NUM_BITS-2:0], bc_sync};
               bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
               cnt_d     = '0;
               if (bit_cnt_q == BIT_CNT_W'(NUM_BITS - 1)) begin
                  state_d = DONE;
               end else begin
                  state_d = WAIT_FALL;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         // A set here overrides a simultaneous clear from dig_core.
         DONE: begin
            if (prefix_ok(shift_q)) begin
               id_d     = shift_q;
               id_vld_d = 1'b1;
            end
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         tlow_q    <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         id_q      <= '0;
         id_vld_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         tlow_q    <= tlow_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         id_q      <= id_d;
         id_vld_q  <= id_vld_d;
      end
   end

   assign ID     = id_q;
   assign ID_vld = id_vld_q;

endmodule

// File: tb/tb_barcode_rdr.sv
// Self-checking bench for barcode_rdr: frames built from pulse lengths, expected IDs
// from a frame-level model (short low = 1, long low = 0, prefix 2'b00 accepted).
module tb_barcode_rdr;

   localparam int unsigned CNT_W   = 10;
   localparam int unsigned MIN_LOW = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       BC;
   logic       clr_ID_vld;
   logic [7:0] ID;
   logic       ID_vld;

   int checks   = 0;
   int failures = 0;

   logic [7:0] exp_id;
   logic       exp_vld;

   always #5 clk = ~clk;

   barcode_rdr #(
      .CNT_W   (CNT_W),
      .MIN_LOW (MIN_LOW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .BC         (BC),
      .clr_ID_vld (clr_ID_vld),
      .ID         (ID),
      .ID_vld     (ID_vld)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic int low_len(input logic b, input int l);
      return b ? l / 2 : 2 * l;
   endfunction

   task automatic drive_cell(input int lo, input int len);
      for (int t = 0; t < len; t++) begin
         BC = (t < lo) ? 1'b0 : 1'b1;
         tick(1);
      end
   endtask

   // Full frame; vld_pre/vld_post are ID_vld just before/at the expected update edge.
   task automatic send_frame(input logic [7:0] data, input int l, input bit race,
                             output logic vld_pre, output logic vld_post);
      vld_pre  = 1'b0;
      vld_post = 1'b0;
      drive_cell(l, 3 * l);
      for (int i = 7; i >= 1; i--) drive_cell(low_len(data[i], l), 3 * l);
      for (int t = 0; t < 3 * l; t++) begin
         BC         = (t < low_len(data[0], l)) ? 1'b0 : 1'b1;
         clr_ID_vld = race && (t == l + 2);
         tick(1);
         if (t == l + 1) vld_pre = ID_vld;
         if (t == l + 2) vld_post = ID_vld;
      end
      clr_ID_vld = 1'b0;
      BC         = 1'b1;
      tick(8);
   endtask

   task automatic model_frame(input logic [7:0] data);
      if (data[7:6] == 2'b00) begin
         exp_id  = data;
         exp_vld = 1'b1;
      end
   endtask

   task automatic pulse_clr();
      clr_ID_vld = 1'b1;
      tick(1);
      clr_ID_vld = 1'b0;
      exp_vld    = 1'b0;
   endtask

   task automatic check_out(input string name);
      checks++;
      if (ID !== exp_id || ID_vld !== exp_vld) begin
         failures++;
         $display("FAIL %s: ID=%h ID_vld=%b, expected ID=%h ID_vld=%b",
                  name, ID, ID_vld, exp_id, exp_vld);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; BC = 1'b1; clr_ID_vld = 1'b0;
      tick(3);
      exp_id = 8'h00; exp_vld = 1'b0;
      check_out("reset_held");
      rst = 1'b0;
      tick(2);
      check_out("reset_released");
   endtask

   task automatic test_valid_id();
      logic pre, post;
      send_frame(8'h10, 100, 1'b0, pre, post);
      model_frame(8'h10);
      checks++;
      if (pre !== 1'b0 || post !== 1'b1) begin
         failures++;
         $display("FAIL valid_latency: pre=%b post=%b, expected pre=0 post=1", pre, post);
      end
      check_out("valid_id");
      tick(20);
      check_out("valid_hold");
      pulse_clr();
      check_out("valid_clr");
   endtask

   task automatic test_bad_prefix();
      logic pre, post;
      int   l;
      l = int'($urandom_range(40, 100));
      send_frame(8'h69, l, 1'b0, pre, post);
      model_frame(8'h69);
      check_out("bad_prefix");
      send_frame(8'h29, l, 1'b0, pre, post);
      model_frame(8'h29);
      check_out("good_after_bad");
      pulse_clr();
   endtask

   task automatic test_glitch_timeout();
      logic pre, post;
      BC = 1'b0;
      tick(3);
      BC = 1'b1;
      tick(20);
      check_out("glitch_no_vld");
      send_frame(8'h1A, 80, 1'b0, pre, post);
      model_frame(8'h1A);
      check_out("frame_after_glitch");
      pulse_clr();
      drive_cell(90, 270);
      for (int i = 7; i >= 4; i--) drive_cell(low_len(1'(i % 2), 90), 270);
      BC = 1'b1;
      tick(1100);
      check_out("timeout_no_vld");
      send_frame(8'h05, 90, 1'b0, pre, post);
      model_frame(8'h05);
      check_out("frame_after_timeout");
   endtask

   task automatic test_handshake_race();
      logic       pre, post;
      logic [7:0] d;
      pulse_clr();
      d = 8'($urandom_range(1, 63));
      send_frame(d, 70, 1'b1, pre, post);
      model_frame(d);
      checks++;
      if (post !== 1'b1) begin
         failures++;
         $display("FAIL race_set_wins: ID_vld=%b, expected 1", post);
      end
      check_out("race_id");
   endtask

   task automatic test_overwrite();
      logic pre, post;
      send_frame(8'h12, 60, 1'b0, pre, post);
      model_frame(8'h12);
      check_out("overwrite_first");
      send_frame(8'h34, 60, 1'b0, pre, post);
      model_frame(8'h34);
      check_out("overwrite_second");
   endtask

   task automatic test_reset_mid_frame();
      logic pre, post;
      int   l;
      l = 60;
      drive_cell(l, 3 * l);
      for (int i = 1; i <= 4; i++) drive_cell(2 * l, 3 * l);
      for (int t = 0; t < 3 * l; t++) begin
         BC  = (t < 2 * l) ? 1'b0 : 1'b1;
         rst = (t == 2 * l + l / 2);
         tick(1);
      end
      rst     = 1'b0;
      exp_id  = 8'h00;
      exp_vld = 1'b0;
      check_out("mid_reset");
      for (int i = 6; i <= 8; i++) drive_cell(2 * l, 3 * l);
      BC = 1'b1;
      tick(1100);
      check_out("mid_reset_leftover");
      send_frame(8'h3F, l, 1'b0, pre, post);
      model_frame(8'h3F);
      check_out("after_mid_reset");
   endtask

   task automatic test_random();
      logic       pre, post;
      logic [7:0] d;
      int         l;
      for (int n = 0; n < 6; n++) begin
         if ($urandom_range(0, 1) == 1) pulse_clr();
         d = 8'($urandom);
         if ($urandom_range(0, 2) != 0) d[7:6] = 2'b00;
         l = int'($urandom_range(40, 100));
         send_frame(d, l, 1'b0, pre, post);
         model_frame(d);
         check_out("random_frame");
      end
   endtask

   initial begin
      rst = 1'b1; BC = 1'b1; clr_ID_vld = 1'b0;
      exp_id = 8'h00; exp_vld = 1'b0;
      test_reset();
      test_valid_id();
      test_bad_prefix();
      test_glitch_timeout();
      test_handshake_race();
      test_overwrite();
      test_reset_mid_frame();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/barcode_rdr.md
Name: barcode_rdr

Overview:
- Serial barcode/ID reader sitting directly upstream of dig_core.
- Decodes the self-timed station-ID barcode seen by the bot's optical sensor into an 8-bit ID.
- Presents the ID to dig_core on the ID/ID_vld/clr_ID_vld handshake.
- Bit timing is learned per frame from the start cell, so the block is speed-independent.

Parameters:
- CNT_W, 22, width of the timing counter; saturation at 2^CNT_W-1 means timeout/abort.
- MIN_LOW, 8, minimum start-cell low time in clk cycles; anything shorter is treated as a glitch.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- BC  in  1  raw asynchronous barcode serial line; idle high
- clr_ID_vld  in  1  from dig_core; clears ID_vld
- ID  out  8  last accepted station ID
- ID_vld  out  1  ID holds a new, unconsumed value

Behaviour:
- Reset: ID=8'h00, ID_vld=0, state=IDLE, counters=0.
- Reset is sampled on clk; if asserted mid-frame, the frame is discarded and nothing is reported.
- Input conditioning:
  - BC passes through a 2-flop synchronizer, then one more flop for edge detection.
  - fall = prev&~cur; rise = ~prev&cur.
  - All timing below is relative to these synchronized edges (2-cycle input latency).
- Frame format:
  - 9 cells; every cell begins with a falling edge.
  - Cell 0 is the start cell: BC is low for Tlow cycles.
  - Cells 1..8 carry data, MSB first.
  - Each data bit is the synchronized BC level sampled exactly Tlow cycles after that cell's falling edge: short low pulse gives 1, long low gives 0.
- State machine:
  - IDLE: cnt=0, bit_cnt=0. On fall -> START.
  - START: cnt increments each cycle while low.
    - On rise: if cnt<MIN_LOW -> IDLE (glitch). Otherwise latch Tlow=cnt, cnt=0 -> WAIT_FALL.
  - WAIT_FALL: cnt increments.
    - On fall: cnt=0 -> SAMPLE_DLY.
    - On cnt saturation -> IDLE (timeout; partial frame dropped).
  - SAMPLE_DLY: cnt increments. When cnt==Tlow-1:
    - shift_reg = {shift_reg[6:0], BC_sync}; bit_cnt++.
    - If bit_cnt becomes 8 -> DONE, else -> WAIT_FALL.
  - DONE (one cycle):
    - If shift_reg[7:6]==2'b00: ID<=shift_reg and ID_vld<=1 on the next clk edge.
    - Otherwise the frame is discarded and ID/ID_vld are unchanged.
    - Then -> IDLE.
  - START saturating without a rise -> IDLE (line stuck low).
- Latency: ID/ID_vld update 1 cycle after the 8th sample (2 cycles incl. DONE register) and 4 cycles after the synchronized raw edge.
- Handshake:
  - ID_vld stays high until clr_ID_vld.
  - clr_ID_vld in the same cycle as a set: set wins (ID_vld=1, new ID).
  - A new valid frame while ID_vld=1 overwrites ID; ID_vld stays 1.
  - ID is never changed except by an accepted frame or rst.
- Edge ignoring:
  - Falls arriving during SAMPLE_DLY are ignored.
  - Rises are ignored outside START.
- Width rules: Tlow and cnt are CNT_W unsigned; the compare uses Tlow-1 (Tlow>=MIN_LOW>=2, so no underflow).

Decomposition:
- Package barcode_pkg:
  - typedef enum logic [2:0] bc_state_t {IDLE, START, WAIT_FALL, SAMPLE_DLY, DONE}
  - localparam ID_PREFIX=2'b00
  - localparam NUM_BITS=8
- Sub-module sync_edge_det: 2-flop synchronizer plus edge flop. Ports clk, rst, async_in, sync_out, fall, rise. Reset value is 1 (idle-high line).

Test Plan:
- Valid ID: Tlow=100 cycles, send 8'h10 (data 0 = 200-cycle low, 1 = 50-cycle low, 300-cycle cells) -> ID=8'h10, ID_vld=1 within 4 cycles of the last sample; ID_vld holds until clr_ID_vld, then 0 next cycle.
- Bad prefix: send 8'b01_101001 -> ID_vld stays 0, ID keeps its previous value. Then send 8'b00_101001 -> ID=8'h29, ID_vld=1.
- Glitch and timeout:
  - 3-cycle low pulse on BC -> stays IDLE, no ID_vld.
  - With CNT_W=10, stop BC after 4 data bits -> returns to IDLE after 1023 cycles.
  - A following full frame of 8'h05 -> ID=8'h05.
- Handshake race: assert clr_ID_vld in the same cycle the frame completes -> ID_vld=1 and ID updated.
- Overwrite: 8'h12 then 8'h34 with no clr -> ID=8'h34, ID_vld=1.
- Reset mid-frame: rst high for 1 cycle during bit 5 -> ID=0, ID_vld=0. The remaining pulses decode no ID; the next full frame of 8'h3F -> ID=8'h3F.
